// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage.
// Owns HI/LO and stalls the pipeline while a radix-2 operation runs.
module ex_muldiv_unit #(
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 6,
    parameter int EARLY_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        aluop_i,
    input  logic [DATA_W-1:0] reg_operation1_i,
    input  logic [DATA_W-1:0] reg_operation2_i,
    input  logic [4:0]        write_regAddress_i,
    input  logic              is_write_i,
    input  logic              flush_i,
    output logic              stall_req_o,
    output logic [4:0]        write_regAddress_o,
    output logic              is_write_o,
    output logic [DATA_W-1:0] write_regValue_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              div_zero_o
);

    localparam logic [7:0] OP_MULT  = 8'b00011000;
    localparam logic [7:0] OP_MULTU = 8'b00011001;
    localparam logic [7:0] OP_DIV   = 8'b00011010;
    localparam logic [7:0] OP_DIVU  = 8'b00011011;
    localparam logic [7:0] OP_MFHI  = 8'b00010000;
    localparam logic [7:0] OP_MTHI  = 8'b00010001;
    localparam logic [7:0] OP_MFLO  = 8'b00010010;
    localparam logic [7:0] OP_MTLO  = 8'b00010011;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   opnd;
    logic [2*DATA_W-1:0] acc;
    logic [CNT_W-1:0]    cnt;
    logic                is_mul_q;
    logic                neg_res;
    logic                neg_rem;
    logic                dz_q;

    logic                op_mul;
    logic                op_div;
    logic                op_signed;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic                issue;
    logic                zero_mul;

    assign op_mul    = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU);
    assign op_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign op_signed = (aluop_i == OP_MULT) || (aluop_i == OP_DIV);
    assign a_neg     = op_signed & reg_operation1_i[DATA_W-1];
    assign b_neg     = op_signed & reg_operation2_i[DATA_W-1];
    assign abs_a     = a_neg ? -reg_operation1_i : reg_operation1_i;
    assign abs_b     = b_neg ? -reg_operation2_i : reg_operation2_i;
    assign issue     = (state == IDLE) && (op_mul || op_div) && !flush_i;
    assign zero_mul  = (EARLY_ZERO != 0) &&
                       ((reg_operation1_i == '0) || (reg_operation2_i == '0));

    // Shift-add step: acc holds {partial product, remaining multiplier bits}
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} +
                      (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[DATA_W-1:1]};

    // Restoring step: acc holds {partial remainder, dividend/quotient bits}
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] div_next;

    assign div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = ~div_diff[DATA_W];
    assign div_next  = {div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0],
                        acc[DATA_W-2:0], div_ge};

    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign prod_fix = neg_res ? -acc : acc;
    assign quo_fix  = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    assign rem_fix  = neg_rem ? -acc[2*DATA_W-1:DATA_W]
                              : acc[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd     <= '0;
            acc      <= '0;
            cnt      <= '0;
            is_mul_q <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            dz_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        is_mul_q <= op_mul;
                        cnt      <= CNT_W'(DATA_W);
                        if (op_mul) begin
                            opnd <= abs_a;
                            if (zero_mul) begin
                                acc   <= '0;
                                state <= DONE;
                            end else begin
                                acc   <= {{DATA_W{1'b0}}, abs_b};
                                state <= MUL;
                            end
                        end else begin
                            opnd <= abs_b;
                            acc  <= {{DATA_W{1'b0}}, abs_a};
                            if (reg_operation2_i == '0) begin
                                dz_q  <= 1'b1;
                                state <= DONE;
                            end else begin
                                state <= DIV;
                            end
                        end
                    end else if (!flush_i) begin
                        if (aluop_i == OP_MTHI) hi_q <= reg_operation1_i;
                        if (aluop_i == OP_MTLO) lo_q <= reg_operation1_i;
                    end
                end
                MUL: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        acc <= mul_next;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= DONE;
                    end
                end
                DIV: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        acc <= div_next;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!flush_i && !dz_q) begin
                        if (is_mul_q) begin
                            hi_q <= prod_fix[2*DATA_W-1:DATA_W];
                            lo_q <= prod_fix[DATA_W-1:0];
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates the issue term so the stall clears the moment reset rises
    assign stall_req_o = (issue && !reset) || (state == MUL) || (state == DIV);
    assign div_zero_o  = dz_q && (state == DONE) && !flush_i;

    always_comb begin
        write_regValue_o = '0;
        is_write_o       = 1'b0;
        if (aluop_i == OP_MFHI) begin
            write_regValue_o = hi_q;
            is_write_o       = is_write_i;
        end else if (aluop_i == OP_MFLO) begin
            write_regValue_o = lo_q;
            is_write_o       = is_write_i;
        end
    end

    assign write_regAddress_o = write_regAddress_i;
    assign hi_o               = hi_q;
    assign lo_o               = lo_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit for the execute stage. It sits beside the single-cycle ALU and handles MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- It owns the HI/LO register pair and runs an iterative radix-2 datapath.
- It raises a stall request to the pipeline controller while an operation is in progress.
- Width is parametrised; a zero-operand early-out is optional.

Parameters:
DATA_W, 32, operand, HI and LO width (must be ≥ 8).
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.
EARLY_ZERO, 1, when 1, MULT/MULTU with either operand equal to 0 completes without iterating.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
aluop_i  in  8  op code: MULT 00011000, MULTU 00011001, DIV 00011010, DIVU 00011011, MFHI 00010000, MTHI 00010001, MFLO 00010010, MTLO 00010011
reg_operation1_i  in  DATA_W  rs value (multiplicand or dividend; source value for MTHI/MTLO)
reg_operation2_i  in  DATA_W  rt value (multiplier or divisor)
write_regAddress_i  in  5  destination register
is_write_i  in  1  decoder write enable
flush_i  in  1  kill the in-flight operation
stall_req_o  out  1  hold IF/ID/EX
write_regAddress_o  out  5  pass-through
is_write_o  out  1  GPR write enable from this unit
write_regValue_o  out  DATA_W  MFHI/MFLO result
hi_o  out  DATA_W  current HI
lo_o  out  DATA_W  current LO
div_zero_o  out  1  one-cycle registered pulse on divide by zero

Behaviour:
- Reset (asynchronous): state=IDLE, HI=0, LO=0, counter=0, div_zero_o=0. Consequently stall_req_o=0 and hi_o=lo_o=0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, op is MULT/MULTU/DIV/DIVU, flush_i=0:
  - stall_req_o=1 combinationally.
  - Latch absolute values of the operands (raw values for the U variants).
  - Latch the sign-fix flags.
  - Load counter=DATA_W.
  - Go to MUL or DIV.
- MUL (shift-add):
  - One iteration per cycle; counter decrements; at counter=1 go to DONE.
  - EARLY_ZERO=1 with a zero operand: IDLE goes straight to DONE, product forced to 0.
- DIV (restoring): one quotient bit per cycle; at counter=1 go to DONE.
- DIV with divisor=0:
  - IDLE goes straight to DONE; HI/LO are not written.
  - div_zero_o pulses in the DONE cycle.
- DONE:
  - stall_req_o=0, so the pipeline advances. The held op is ignored, so there is no restart.
  - At the end of DONE, HI/LO are written: MUL writes {HI,LO}=2*DATA_W product; DIV writes LO=quotient, HI=remainder.
  - Next state is IDLE.
- Latency: stall_req_o is high for DATA_W+1 cycles (issue cycle + DATA_W iterations). The result is visible on hi_o/lo_o in the cycle after DONE. The early-out and divide-by-zero paths stall for 1 cycle.
- Signed fix-up:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - MIN/−1 gives quotient=MIN, remainder=0; no trap.
- stall_req_o is 1 in IDLE-issue, MUL and DIV; 0 in DONE and otherwise. The upstream stage holds its inputs stable while stall_req_o=1.
- flush_i=1 in MUL/DIV/DONE: next state IDLE, no HI/LO write, no div_zero_o pulse. flush_i in IDLE blocks issue.
- MTHI/MTLO:
  - Write HI/LO at the clock edge when state=IDLE and flush_i=0.
  - is_write_o=0.
- MFHI/MFLO:
  - write_regValue_o=HI or LO combinationally, is_write_o=is_write_i.
  - An MTHI/MFHI pair in back-to-back cycles reads the new value.
- All other ops and MDU ops: is_write_o=0, write_regValue_o=0.
- write_regAddress_o always equals write_regAddress_i.
- An op code arriving while in MUL/DIV has no effect; the upstream holds it anyway.

Test Plan:
1. MULT −3 × 7 (DATA_W=32) → stall_req_o high exactly 33 cycles; then HI=FFFFFFFF, LO=FFFFFFEB; next MFLO gives write_regValue_o=FFFFFFEB, is_write_o=1.
2. MULTU FFFFFFFF × FFFFFFFF → HI=FFFFFFFE, LO=00000001. MULT 0 × 1234 with EARLY_ZERO=1 → 1-cycle stall, HI=LO=0.
3. DIV −7 / 2 → LO=FFFFFFFD, HI=FFFFFFFF. DIVU 100 / 7 → LO=14, HI=2. DIV 80000000 / FFFFFFFF → LO=80000000, HI=0.
4. DIV 5 / 0 with HI=AA, LO=BB beforehand → 1-cycle stall, div_zero_o pulses once, HI/LO unchanged.
5. Flush in MUL cycle 10 → stall drops next cycle, HI/LO unchanged; a following MTLO 55 then MFLO → 55.
6. Reset asserted mid-DIV, asynchronously → stall_req_o, HI and LO go to 0 immediately. A DIV issued after release completes normally.
